// File: rtl/mult_product_accumulator.sv
// Sums a batch of BATCH 4-bit multiplier products into an ACC_WIDTH-bit total.
// The total and a sticky overflow flag are handed downstream via valid/ready.
module mult_product_accumulator #(
  parameter int ACC_WIDTH = 8,
  parameter int BATCH     = 4,
  localparam int CNT_WIDTH = $clog2(BATCH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 prod_valid,
  input  logic [3:0]           prod,
  output logic                 prod_ready,
  output logic                 acc_valid,
  input  logic                 acc_ready,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 accept;
  logic [ACC_WIDTH:0]   sum;
  logic                 last_prod;

  assign accept    = prod_valid && prod_ready;
  assign last_prod = (count_q == CNT_WIDTH'(BATCH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      overflow_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (BATCH == 1) ? DONE : ACCUM;
      ACCUM:   if (accept && last_prod) state_d = DONE;
      DONE:    if (acc_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prod_ready = 1'b0;
    acc_valid  = 1'b0;
    busy       = 1'b0;
    case (state_q)
      IDLE:    prod_ready = 1'b1;
      ACCUM: begin
        prod_ready = 1'b1;
        busy       = 1'b1;
      end
      DONE: begin
        acc_valid = 1'b1;
        busy      = 1'b1;
      end
      default: prod_ready = 1'b0;
    endcase
  end

  // prod only enters the sum under accept, so X on an idle bus never reaches state.
  always_comb begin
    sum        = {1'b0, acc_q} + (ACC_WIDTH + 1)'(prod);
    acc_d      = acc_q;
    overflow_d = overflow_q;
    count_d    = count_q;
    if (state_q == DONE) begin
      if (acc_ready) begin
        acc_d      = '0;
        overflow_d = 1'b0;
        count_d    = '0;
      end
    end else if (accept) begin
      acc_d      = sum[ACC_WIDTH-1:0];
      overflow_d = overflow_q | sum[ACC_WIDTH];
      count_d    = count_q + CNT_WIDTH'(1);
    end
  end

  assign acc_out  = acc_q;
  assign overflow = overflow_q;
  assign count    = count_q;

endmodule

// File: tb/tb_mult_product_accumulator.sv
// Drives three accumulator configurations from one shared input stream and
// compares every output against a per-instance batch-sum model each cycle.
module tb_mult_product_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       prod_valid;
  logic [3:0] prod;
  logic       acc_ready;

  logic       a_pr, a_av, a_ovf, a_busy;
  logic [7:0] a_acc;
  logic [2:0] a_cnt;
  logic       b_pr, b_av, b_ovf, b_busy;
  logic [4:0] b_acc;
  logic [2:0] b_cnt;
  logic       c_pr, c_av, c_ovf, c_busy;
  logic [7:0] c_acc;
  logic [0:0] c_cnt;

  always #5 clk = ~clk;

  mult_product_accumulator #(.ACC_WIDTH(8), .BATCH(4)) u_a (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod(prod), .prod_ready(a_pr),
    .acc_valid(a_av), .acc_ready(acc_ready), .acc_out(a_acc), .overflow(a_ovf),
    .count(a_cnt), .busy(a_busy)
  );

  mult_product_accumulator #(.ACC_WIDTH(5), .BATCH(4)) u_b (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod(prod), .prod_ready(b_pr),
    .acc_valid(b_av), .acc_ready(acc_ready), .acc_out(b_acc), .overflow(b_ovf),
    .count(b_cnt), .busy(b_busy)
  );

  mult_product_accumulator #(.ACC_WIDTH(8), .BATCH(1)) u_c (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod(prod), .prod_ready(c_pr),
    .acc_valid(c_av), .acc_ready(acc_ready), .acc_out(c_acc), .overflow(c_ovf),
    .count(c_cnt), .busy(c_busy)
  );

  logic [7:0] o_acc  [3];
  logic [2:0] o_cnt  [3];
  logic       o_ovf  [3];
  logic       o_av   [3];
  logic       o_pr   [3];
  logic       o_busy [3];

  assign o_acc[0] = a_acc;
  assign o_acc[1] = {3'b000, b_acc};
  assign o_acc[2] = c_acc;
  assign o_cnt[0] = a_cnt;
  assign o_cnt[1] = b_cnt;
  assign o_cnt[2] = {2'b00, c_cnt};
  assign o_ovf[0] = a_ovf;
  assign o_ovf[1] = b_ovf;
  assign o_ovf[2] = c_ovf;
  assign o_av[0]  = a_av;
  assign o_av[1]  = b_av;
  assign o_av[2]  = c_av;
  assign o_pr[0]  = a_pr;
  assign o_pr[1]  = b_pr;
  assign o_pr[2]  = c_pr;
  assign o_busy[0] = a_busy;
  assign o_busy[1] = b_busy;
  assign o_busy[2] = c_busy;

  // Model: true (unbounded) batch sum; the register holds it mod 2^W and the
  // sticky flag is set exactly when the true sum has reached 2^W.
  int m_batch [3] = '{4, 4, 1};
  int m_width [3] = '{8, 5, 8};
  int m_sum   [3];
  int m_cnt   [3];
  bit m_done  [3];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int inst, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[inst %0d] t=%0t observed=%0d expected=%0d", tag, inst, $time, obs, exp);
    end
  endtask

  task automatic step(input bit pv, input logic [3:0] p, input bit ar, input bit r);
    prod_valid = pv;
    prod       = pv ? p : 4'bxxxx;
    acc_ready  = ar;
    rst        = r;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (r || (m_done[i] && ar)) begin
        m_sum[i]  = 0;
        m_cnt[i]  = 0;
        m_done[i] = 1'b0;
      end else if (pv && !m_done[i]) begin
        m_sum[i]  = m_sum[i] + int'(p);
        m_cnt[i]  = m_cnt[i] + 1;
        m_done[i] = (m_cnt[i] == m_batch[i]);
      end
      check("acc_out",    i, 32'(o_acc[i]),  32'(m_sum[i] % (1 << m_width[i])));
      check("overflow",   i, 32'(o_ovf[i]),  32'(m_sum[i] >= (1 << m_width[i])));
      check("count",      i, 32'(o_cnt[i]),  32'(m_cnt[i]));
      check("acc_valid",  i, 32'(o_av[i]),   32'(m_done[i]));
      check("prod_ready", i, 32'(o_pr[i]),   32'(!m_done[i]));
      check("busy",       i, 32'(o_busy[i]), 32'(m_cnt[i] != 0));
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_sum[i]  = 0;
      m_cnt[i]  = 0;
      m_done[i] = 1'b0;
    end

    step(0, 4'd0, 0, 1);
    step(0, 4'd0, 1, 0);

    // back-to-back 9s: default stays clean, 5-bit instance wraps on the last add
    repeat (4) step(1, 4'd9, 0, 0);
    step(0, 4'd0, 0, 0);
    step(0, 4'd0, 1, 0);

    // gapped batch 1,4,0,6 with gaps 0,3,1
    step(1, 4'd1, 0, 0);
    step(1, 4'd4, 0, 0);
    repeat (3) step(0, 4'd0, 0, 0);
    step(1, 4'd0, 0, 0);
    step(0, 4'd0, 0, 0);
    step(1, 4'd6, 0, 0);

    // held in DONE while upstream keeps offering 9, then handoff, then accept
    repeat (6) step(1, 4'd9, 0, 0);
    step(1, 4'd9, 1, 0);
    step(1, 4'd9, 0, 0);
    step(0, 4'd0, 0, 0);

    // reset mid-batch, then reset while in DONE
    step(0, 4'd0, 1, 1);
    step(1, 4'd2, 0, 0);
    step(1, 4'd3, 0, 0);
    step(0, 4'd0, 0, 1);
    repeat (4) step(1, 4'd9, 0, 0);
    step(0, 4'd0, 0, 0);
    step(0, 4'd0, 0, 1);
    step(0, 4'd0, 1, 0);

    for (int n = 0; n < 400; n++) begin
      bit         pv, ar, r;
      logic [3:0] p;
      pv = ($urandom_range(0, 9) < 7);
      p  = 4'($urandom_range(0, 3) * $urandom_range(0, 3));
      ar = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 59) == 0);
      step(pv, p, ar, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
